// File: rtl/adc_capture_pkg.sv
// Shared types, widths and header layout for the ADC capture path.
// The header decimation field is only non-zero when ADC_CAPTURE_DECIMATE_EN is defined.
package adc_capture_pkg;

   localparam int AXIS_DATA_WIDTH = 256;
   localparam int FIFO_DATA_WIDTH = 128;
   localparam int COUNT_WIDTH     = 16;
   localparam int TIME_WIDTH      = 64;
   localparam int DEC_WIDTH       = 8;

   localparam logic [15:0] HEADER_MAGIC = 16'hADC0;

   localparam int HDR_TS_LSB    = 64;
   localparam int HDR_COUNT_LSB = 48;
   localparam int HDR_MAGIC_LSB = 32;
   localparam int HDR_DEC_LSB   = 24;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   function automatic logic [FIFO_DATA_WIDTH-1:0] build_header(
      input logic [TIME_WIDTH-1:0]  ts,
      input logic [COUNT_WIDTH-1:0] count,
      input logic [DEC_WIDTH-1:0]   dec
   );
      logic [FIFO_DATA_WIDTH-1:0] hdr;
      hdr = '0;
      hdr[HDR_TS_LSB    +: TIME_WIDTH]  = ts;
      hdr[HDR_COUNT_LSB +: COUNT_WIDTH] = count;
      hdr[HDR_MAGIC_LSB +: 16]          = HEADER_MAGIC;
      hdr[HDR_DEC_LSB   +: DEC_WIDTH]   = dec;
      return hdr;
   endfunction

endpackage

// File: rtl/adc_beat_serializer.sv
// Holds one 256-bit ADC beat and emits it as two 128-bit words, low half first,
// advancing only when the write slot is not stalled.
module adc_beat_serializer
   import adc_capture_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       load,
   input  logic                       stall,
   input  logic [AXIS_DATA_WIDTH-1:0] beat,
   output logic                       hold_valid,
   output logic                       word_valid,
   output logic [FIFO_DATA_WIDTH-1:0] word
);

   logic [AXIS_DATA_WIDTH-1:0] hold_r;
   logic                       hold_valid_r;
   logic                       phase_hi_r;

   // Hold register and lo/hi phase; a load can only occur while the hold is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_r       <= '0;
         hold_valid_r <= 1'b0;
         phase_hi_r   <= 1'b0;
      end else if (clear) begin
         hold_valid_r <= 1'b0;
         phase_hi_r   <= 1'b0;
      end else if (load) begin
         hold_r       <= beat;
         hold_valid_r <= 1'b1;
         phase_hi_r   <= 1'b0;
      end else if (word_valid) begin
         if (phase_hi_r) begin
            hold_valid_r <= 1'b0;
            phase_hi_r   <= 1'b0;
         end else begin
            phase_hi_r   <= 1'b1;
         end
      end
   end

   assign hold_valid = hold_valid_r;
   assign word_valid = hold_valid_r && !stall;
   assign word       = phase_hi_r ? hold_r[AXIS_DATA_WIDTH-1:FIFO_DATA_WIDTH]
                                  : hold_r[FIFO_DATA_WIDTH-1:0];

endmodule

// File: rtl/adc_capture_controller.sv
// Timestamped ADC capture: waits for the timeline counter to reach the armed start
// time, then writes a header plus N beats as 128-bit FIFO words (ADC_CAPTURE_DECIMATE_EN adds decimation).
module adc_capture_controller
   import adc_capture_pkg::*;
(
   input  logic                       s_axi_aclk,
   input  logic                       s_axi_aresetn,
   input  logic [AXIS_DATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                       s00_axis_tvalid,
   output logic                       s00_axis_tready,
   input  logic [TIME_WIDTH-1:0]      counter,
   input  logic                       arm,
   input  logic                       abort,
   input  logic [TIME_WIDTH-1:0]      start_time,
   input  logic [COUNT_WIDTH-1:0]     sample_count,
`ifdef ADC_CAPTURE_DECIMATE_EN
   input  logic [DEC_WIDTH-1:0]       decimation,
`endif
   output logic [FIFO_DATA_WIDTH-1:0] fifo_din,
   output logic                       fifo_write,
   input  logic                       fifo_full,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow_error
);

   state_t                     state_r, state_nxt_s;
   logic [TIME_WIDTH-1:0]      start_time_r, trigger_ts_r;
   logic [COUNT_WIDTH-1:0]     count_r, remaining_r;
   logic                       header_pending_r, overflow_r, done_r, fifo_write_r;
   logic [FIFO_DATA_WIDTH-1:0] fifo_din_r;

   logic                       in_capture_s, tready_s, arm_take_s, trigger_s, finish_s;
   logic                       accept_s, keep_s, hdr_wr_s, ser_stall_s, wr_s;
   logic                       hold_valid_s, word_valid_s;
   logic [FIFO_DATA_WIDTH-1:0] word_s, wr_data_s;
   logic [DEC_WIDTH-1:0]       dec_field_s;

   assign in_capture_s = (state_r == ST_CAPTURE);
   assign tready_s     = !in_capture_s || !hold_valid_s;
   assign arm_take_s   = (state_r == ST_IDLE) && arm && !abort;
   assign trigger_s    = (state_r == ST_ARMED) && (counter >= start_time_r) && !abort;
   assign finish_s     = in_capture_s && !abort && (remaining_r == '0)
                         && !hold_valid_s && !header_pending_r;
   assign accept_s     = in_capture_s && !abort && s00_axis_tvalid && tready_s
                         && (remaining_r != '0);
   // The header always wins the single write slot over beat data.
   assign hdr_wr_s     = in_capture_s && !abort && !fifo_full && header_pending_r;
   assign ser_stall_s  = !in_capture_s || abort || fifo_full || header_pending_r;
   assign wr_s         = hdr_wr_s || word_valid_s;
   assign wr_data_s    = hdr_wr_s ? build_header(trigger_ts_r, count_r, dec_field_s) : word_s;

`ifdef ADC_CAPTURE_DECIMATE_EN
   logic [DEC_WIDTH-1:0] dec_r, dec_cnt_r;

   // Decimation ratio latched on arm; the keep phase restarts at each trigger.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         dec_r     <= '0;
         dec_cnt_r <= '0;
      end else begin
         if (arm_take_s) dec_r <= decimation;
         if (trigger_s) begin
            dec_cnt_r <= '0;
         end else if (accept_s) begin
            dec_cnt_r <= (dec_cnt_r == dec_r) ? '0 : dec_cnt_r + 8'd1;
         end
      end
   end

   assign keep_s      = accept_s && (dec_cnt_r == '0);
   assign dec_field_s = dec_r;
`else
   assign keep_s      = accept_s;
   assign dec_field_s = '0;
`endif

   adc_beat_serializer u_serializer (
      .clk        (s_axi_aclk),
      .rst_n      (s_axi_aresetn),
      .clear      (abort),
      .load       (keep_s),
      .stall      (ser_stall_s),
      .beat       (s00_axis_tdata),
      .hold_valid (hold_valid_s),
      .word_valid (word_valid_s),
      .word       (word_s)
   );

   // Next-state selection; abort from any state returns to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (arm_take_s && (sample_count != '0)) state_nxt_s = ST_ARMED;
            else                                   state_nxt_s = ST_IDLE;
         end
         ST_ARMED: begin
            if (abort)          state_nxt_s = ST_IDLE;
            else if (trigger_s) state_nxt_s = ST_CAPTURE;
            else                state_nxt_s = ST_ARMED;
         end
         ST_CAPTURE: begin
            if (abort || finish_s) state_nxt_s = ST_IDLE;
            else                   state_nxt_s = ST_CAPTURE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, latched arm parameters, capture bookkeeping and registered outputs.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_r          <= ST_IDLE;
         start_time_r     <= '0;
         trigger_ts_r     <= '0;
         count_r          <= '0;
         remaining_r      <= '0;
         header_pending_r <= 1'b0;
         overflow_r       <= 1'b0;
         done_r           <= 1'b0;
         fifo_write_r     <= 1'b0;
         fifo_din_r       <= '0;
      end else begin
         state_r      <= state_nxt_s;
         done_r       <= finish_s || (arm_take_s && (sample_count == '0));
         fifo_write_r <= wr_s;
         if (wr_s) fifo_din_r <= wr_data_s;
         if (arm_take_s) begin
            start_time_r <= start_time;
            count_r      <= sample_count;
            remaining_r  <= sample_count;
         end else if (keep_s) begin
            remaining_r  <= remaining_r - {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
         end
         // The RFDC ignores tready, so a refused beat is simply lost.
         if (arm_take_s) begin
            overflow_r <= 1'b0;
         end else if (in_capture_s && s00_axis_tvalid && !tready_s) begin
            overflow_r <= 1'b1;
         end
         if (trigger_s) begin
            trigger_ts_r     <= counter;
            header_pending_r <= 1'b1;
         end else if (hdr_wr_s || abort) begin
            header_pending_r <= 1'b0;
         end
      end
   end

   assign s00_axis_tready = tready_s;
   assign fifo_din        = fifo_din_r;
   assign fifo_write      = fifo_write_r;
   assign busy            = (state_r != ST_IDLE);
   assign done            = done_r;
   assign overflow_error  = overflow_r;

endmodule

// File: tb/tb_adc_capture_controller.sv
// Self-checking bench for adc_capture_controller: a queue-based model of owed FIFO
// words checked every cycle, plus hand-computed expectations per directed scenario.
module tb_adc_capture_controller;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [255:0] s00_axis_tdata;
   logic         s00_axis_tvalid;
   logic         s00_axis_tready;
   logic [63:0]  counter;
   logic         arm, abort;
   logic [63:0]  start_time;
   logic [15:0]  sample_count;
   logic [127:0] fifo_din;
   logic         fifo_write;
   logic         fifo_full;
   logic         busy, done, overflow_error;

   int checks = 0;
   int errors = 0;

   adc_capture_controller dut (
      .s_axi_aclk      (clk),
      .s_axi_aresetn   (rst_n),
      .s00_axis_tdata  (s00_axis_tdata),
      .s00_axis_tvalid (s00_axis_tvalid),
      .s00_axis_tready (s00_axis_tready),
      .counter         (counter),
      .arm             (arm),
      .abort           (abort),
      .start_time      (start_time),
      .sample_count    (sample_count),
      .fifo_din        (fifo_din),
      .fifo_write      (fifo_write),
      .fifo_full       (fifo_full),
      .busy            (busy),
      .done            (done),
      .overflow_error  (overflow_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model: words owed to the FIFO ----------------
   typedef enum int {M_IDLE, M_ARMED, M_CAP} mstate_e;
   mstate_e      m_state = M_IDLE;
   logic [127:0] m_q[$];
   bit           m_hdr = 1'b0;
   int           m_rem = 0;
   logic [15:0]  m_cnt = 16'd0;
   logic [63:0]  m_start = 64'd0;
   bit           e_write = 1'b0, e_done = 1'b0, e_ovf = 1'b0;
   logic [127:0] e_din = 128'd0;

   function automatic bit model_tready();
      return (m_state != M_CAP) || ((m_q.size() - int'(m_hdr)) == 0);
   endfunction

   task automatic model_step();
      bit tr, acc;
      e_write = 1'b0;
      e_done  = 1'b0;
      if (!rst_n) begin
         m_state = M_IDLE; m_q.delete(); m_hdr = 1'b0; m_rem = 0; e_ovf = 1'b0;
         return;
      end
      tr = model_tready();
      if (m_state == M_CAP && s00_axis_tvalid && !tr) e_ovf = 1'b1;
      if (abort) begin
         m_state = M_IDLE; m_q.delete(); m_hdr = 1'b0;
      end else begin
         case (m_state)
            M_IDLE: if (arm) begin
               m_cnt = sample_count; m_start = start_time; m_rem = int'(sample_count);
               e_ovf = 1'b0;
               if (sample_count == 16'd0) e_done = 1'b1;
               else m_state = M_ARMED;
            end
            M_ARMED: if (counter >= m_start) begin
               m_q.push_back({counter, m_cnt, 16'hADC0, 32'h0});
               m_hdr = 1'b1;
               m_state = M_CAP;
            end
            M_CAP: begin
               if (m_rem == 0 && m_q.size() == 0) begin
                  e_done = 1'b1;
                  m_state = M_IDLE;
               end else begin
                  acc = s00_axis_tvalid && tr && (m_rem != 0);
                  if (!fifo_full && m_q.size() != 0) begin
                     e_write = 1'b1;
                     e_din = m_q.pop_front();
                     m_hdr = 1'b0;
                  end
                  if (acc) begin
                     m_q.push_back(s00_axis_tdata[127:0]);
                     m_q.push_back(s00_axis_tdata[255:128]);
                     m_rem--;
                  end
               end
            end
            default: m_state = M_IDLE;
         endcase
      end
   endtask

   logic [127:0] wlog[$];
   int n_writes = 0, n_done = 0;

   // Compare process: inputs are unchanged since the last rising edge here.
   always @(negedge clk) begin
      model_step();
      check("cmp_write", 128'(fifo_write), 128'(e_write));
      if (e_write) check("cmp_din", fifo_din, e_din);
      check("cmp_done", 128'(done), 128'(e_done));
      check("cmp_busy", 128'(busy), 128'(m_state != M_IDLE));
      check("cmp_ovf", 128'(overflow_error), 128'(e_ovf));
      check("cmp_tready", 128'(s00_axis_tready), 128'(model_tready()));
      if (fifo_write) begin wlog.push_back(fifo_din); n_writes++; end
      if (done) n_done++;
   end

   // ---------------- stimulus ----------------
   int          mode = 0;    // 0: idle, 1: source follows tready, 2: free-running RFDC
   logic [63:0] gate = 64'd0;
   logic [31:0] k = 32'd0;

   task automatic set_tdata();
      logic [31:0] lo, hi;
      lo = 32'hA000_0000 + k;
      hi = 32'hB000_0000 + k;
      s00_axis_tdata = {{4{hi}}, {4{lo}}};
   endtask

   task automatic cyc();
      bit hs;
      hs = s00_axis_tvalid && s00_axis_tready;
      @(negedge clk); #2;
      arm = 1'b0; abort = 1'b0;
      counter = counter + 64'd1;
      if (mode == 2 || hs) k = k + 32'd1;
      s00_axis_tvalid = (mode == 2) || ((mode == 1) && s00_axis_tready && (counter >= gate));
      set_tdata();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic start_test(input logic [63:0] cnt, input int md, input logic [63:0] g);
      wlog.delete(); n_writes = 0; n_done = 0;
      counter = cnt; mode = md; gate = g; k = 32'd0; set_tdata();
   endtask

   logic [127:0] basic_exp [7];
   logic [127:0] exp_hi;

   initial begin
      rst_n = 1'b1; arm = 1'b0; abort = 1'b0; fifo_full = 1'b0;
      s00_axis_tvalid = 1'b0; counter = 64'd0; start_time = 64'd0; sample_count = 16'd0;
      set_tdata();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      check("rst_tready", 128'(s00_axis_tready), 128'd1);
      check("rst_write", 128'(fifo_write), 128'd0);
      check("rst_din", fifo_din, 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      check("rst_ovf", 128'(overflow_error), 128'd0);
      rst_n = 1'b1;
      cyc();

      // Basic capture: start 100, 3 beats, source honours tready.
      start_test(64'd90, 1, 64'd101);
      start_time = 64'd100; sample_count = 16'd3; arm = 1'b1;
      cyc();
      run(40);
      basic_exp = '{128'h0000_0000_0000_0064_0003_ADC0_0000_0000,
                    {4{32'hA000_0000}}, {4{32'hB000_0000}},
                    {4{32'hA000_0001}}, {4{32'hB000_0001}},
                    {4{32'hA000_0002}}, {4{32'hB000_0002}}};
      check("basic_nwrites", 128'(n_writes), 128'd7);
      if (wlog.size() == 7) begin
         for (int i = 0; i < 7; i++) check("basic_word", wlog[i], basic_exp[i]);
      end
      check("basic_done", 128'(n_done), 128'd1);
      check("basic_ovf", 128'(overflow_error), 128'd0);
      check("basic_busy", 128'(busy), 128'd0);

      // Start time in the past: trigger on the first ARMED cycle with counter 1001.
      start_test(64'd1000, 1, 64'd1002);
      start_time = 64'd5; sample_count = 16'd1; arm = 1'b1;
      cyc();
      run(20);
      check("past_nwrites", 128'(n_writes), 128'd3);
      if (wlog.size() != 0) check("past_header", wlog[0], 128'h0000_0000_0000_03E9_0001_ADC0_0000_0000);
      check("past_done", 128'(n_done), 128'd1);

      // Backpressure: free-running beats, FIFO full for 4 cycles mid-capture.
      start_test(64'd2000, 2, 64'd0);
      start_time = 64'd2002; sample_count = 16'd4; arm = 1'b1;
      cyc();
      run(4);
      fifo_full = 1'b1;
      run(4);
      fifo_full = 1'b0;
      run(40);
      mode = 0;
      check("bp_ovf", 128'(overflow_error), 128'd1);
      check("bp_done", 128'(n_done), 128'd1);
      check("bp_nwrites", 128'(n_writes), 128'd9);
      if (wlog.size() == 9) begin
         check("bp_header", wlog[0], 128'h0000_0000_0000_07D2_0004_ADC0_0000_0000);
         for (int i = 0; i < 4; i++) begin
            exp_hi = {4{wlog[2*i+1][31:0] + 32'h1000_0000}};
            check("bp_pair", wlog[2*i+2], exp_hi);
         end
      end

      // Zero count: done one cycle after arm, nothing written, overflow cleared.
      start_test(64'd2500, 0, 64'd0);
      sample_count = 16'd0; start_time = 64'd0; arm = 1'b1;
      cyc();
      check("zero_done_pulse", 128'(done), 128'd1);
      check("zero_ovf_clr", 128'(overflow_error), 128'd0);
      cyc();
      check("zero_done_low", 128'(done), 128'd0);
      run(5);
      check("zero_nwrites", 128'(n_writes), 128'd0);
      check("zero_ndone", 128'(n_done), 128'd1);

      // Abort after 2 of 10 beats, then a normal re-arm.
      start_test(64'd3000, 1, 64'd3002);
      start_time = 64'd3001; sample_count = 16'd10; arm = 1'b1;
      cyc();
      for (int i = 0; i < 60 && k < 32'd2; i++) cyc();
      check("abort_reach2", 128'(k), 128'd2);
      abort = 1'b1; n_writes = 0; n_done = 0;
      cyc();
      check("abort_busy", 128'(busy), 128'd0);
      run(20);
      check("abort_nwrites", 128'(n_writes), 128'd0);
      check("abort_ndone", 128'(n_done), 128'd0);
      start_test(64'd4000, 1, 64'd4002);
      start_time = 64'd4001; sample_count = 16'd1; arm = 1'b1;
      cyc();
      run(20);
      check("rearm_nwrites", 128'(n_writes), 128'd3);
      check("rearm_done", 128'(n_done), 128'd1);

      // arm and abort together: abort wins.
      start_test(64'd4500, 0, 64'd0);
      start_time = 64'd0; sample_count = 16'd5; arm = 1'b1; abort = 1'b1;
      cyc();
      check("armabort_busy", 128'(busy), 128'd0);
      run(3);
      check("armabort_ndone", 128'(n_done), 128'd0);

      // Asynchronous reset in CAPTURE with overflow set.
      start_test(64'd5000, 2, 64'd0);
      start_time = 64'd5001; sample_count = 16'd4; arm = 1'b1;
      cyc();
      run(6);
      check("ares_pre_busy", 128'(busy), 128'd1);
      check("ares_pre_ovf", 128'(overflow_error), 128'd1);
      #1 rst_n = 1'b0;
      #1;
      check("ares_tready", 128'(s00_axis_tready), 128'd1);
      check("ares_write", 128'(fifo_write), 128'd0);
      check("ares_din", fifo_din, 128'd0);
      check("ares_busy", 128'(busy), 128'd0);
      check("ares_done", 128'(done), 128'd0);
      check("ares_ovf", 128'(overflow_error), 128'd0);
      mode = 0;
      s00_axis_tvalid = 1'b0;
      @(negedge clk); #2;
      rst_n = 1'b1;
      run(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_capture_controller.md
Name: adc_capture_controller

Overview:
Receive-side counterpart of the DAC path. Accepts 256-bit RFDC ADC AXI-Stream beats and waits for the shared 64-bit timeline counter to reach an armed start time. Then captures a fixed number of beats and serializes them, behind a timestamped header word, into a 128-bit FIFO write interface for AXI readout. Sits between the RFDC ADC tile and the readout FIFO that feeds AXI2FIFO-style read logic.

Parameters:
AXIS_DATA_WIDTH, 256, ADC stream beat width; fixed at 2x FIFO_DATA_WIDTH.
FIFO_DATA_WIDTH, 128, readout FIFO word width.
COUNT_WIDTH, 16, width of the sample_count (beat count) field.
HEADER_MAGIC, 16'hADC0, tag placed in each header word.

Ports:
s_axi_aclk  in  1  single block clock; the ADC stream is synchronous to it.
s_axi_aresetn  in  1  asynchronous active-low reset.
s00_axis_tdata  in  256  ADC sample beat.
s00_axis_tvalid  in  1  beat valid.
s00_axis_tready  out  1  beat accepted.
counter  in  64  global timeline counter.
arm  in  1  single-cycle arm request.
abort  in  1  single-cycle abort request.
start_time  in  64  trigger time, sampled on arm.
sample_count  in  16  beats to capture, sampled on arm.
fifo_din  out  128  readout word.
fifo_write  out  1  write strobe.
fifo_full  in  1  readout FIFO full.
busy  out  1  high in ARMED or CAPTURE.
done  out  1  one-cycle pulse on normal completion.
overflow_error  out  1  sticky lost-beat flag.

Behaviour:
- Reset values: state IDLE; s00_axis_tready=1; fifo_write=0; fifo_din=0; busy=0; done=0; overflow_error=0; all latches cleared.
- States are IDLE, ARMED and CAPTURE.
- IDLE:
  - tready=1; beats are discarded.
  - arm latches start_time, sample_count and remaining=sample_count, clears overflow_error, and moves to ARMED.
  - If sample_count==0, stay in IDLE and pulse done the next cycle.
- ARMED:
  - tready=1; beats are discarded.
  - Trigger fires when counter >= start_time (unsigned). A start_time in the past triggers the next cycle.
  - On the trigger cycle, latch trigger_ts=counter, set header_pending=1 and go to CAPTURE.
- CAPTURE:
  - tready = !hold_valid. An accepted beat loads the hold register (hi/lo halves), sets hold_valid and decrements remaining.
  - No beat is accepted once remaining==0.
  - Write priority per cycle, one write max, only when !fifo_full: header, then hold lo [127:0], then hold hi [255:128]. hold_valid clears in the same cycle hi is written.
  - Header layout: [127:64] trigger_ts; [63:48] latched sample_count; [47:32] HEADER_MAGIC; [31:0] zero.
  - fifo_din and fifo_write are registered: one-cycle latency from the write decision.
  - Completion: remaining==0, !hold_valid and !header_pending. Then pulse done and go to IDLE.
- overflow_error: set when tvalid=1 and tready=0 in CAPTURE. The RFDC does not honour backpressure, so the beat is lost. Capture continues; remaining counts accepted beats only.
- abort: from any state, go to IDLE next cycle. Hold and header are dropped, no done pulse. Words already written stay in the FIFO.
- arm while busy is ignored. arm and abort in the same cycle: abort wins.
- Async reset mid-operation clears everything immediately; partial data is not flushed.

Optional Feature:
ADC_CAPTURE_DECIMATE_EN
- Defined:
  - Adds port decimation (in, 8): keep every (decimation+1)th accepted beat, counting from the first beat after trigger.
  - Skipped beats are consumed (tready as above) but not written and not counted in remaining.
  - header[31:24]=decimation.
- Undefined: port absent, every beat kept, header[31:24]=0.

Decomposition:
- Package adc_capture_pkg holds:
  - the state enum;
  - HEADER_MAGIC;
  - width constants;
  - the header field bit positions;
  - a header-build function.
- Sub-module adc_beat_serializer: 256-bit hold register plus lo/hi phase, converting one accepted beat into two 128-bit FIFO writes under fifo_full stall.
- The FSM, trigger compare and counters stay in the top.

Test Plan:
- Basic capture:
  - Stimulus: arm start_time=100, sample_count=3, continuous beats, fifo_full=0.
  - Response: header {ts=100, 3, 16'hADC0, 0} written, then 6 words lo/hi in order, done pulse, busy falls, overflow_error=0.
- Past start:
  - Stimulus: arm start_time=5 with counter=1000.
  - Response: trigger the next cycle, header ts=1001 (counter on the trigger cycle).
- Backpressure:
  - Stimulus: fifo_full held high 4 cycles mid-capture, tvalid continuous.
  - Response: overflow_error=1, written data only from accepted beats, hi/lo order preserved, done still pulses.
- Zero count: arm with sample_count=0 -> no FIFO writes, done pulse 1 cycle later.
- Abort:
  - Stimulus: abort after 2 of 10 beats.
  - Response: IDLE next cycle, no further writes, no done. A subsequent arm works normally.
- Reset and arm races:
  - Stimulus: assert s_axi_aresetn=0 asynchronously in CAPTURE.
  - Response: all outputs at reset values without a clock edge.
  - Stimulus: arm+abort in the same cycle.
  - Response: remain IDLE.
